// File: rtl/word_store_serializer_pkg.sv
// Shared types and helpers for the byte-serial store path.
// Lane selection is the only endian-dependent piece.
package store_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // Byte lane for address offset idx; big-endian puts offset 0 in [31:24].
  function automatic logic [7:0] byte_sel(
    input logic [31:0] data,
    input logic [1:0]  idx,
    input logic        big_endian
  );
    logic [1:0] lane;
    lane = big_endian ? ~idx : idx;
    return data[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/word_store_serializer_be_next_sel.sv
// Finds the first enabled byte, or the next one above cur_idx.
// Purely combinational; lowest qualifying bit wins.
module be_next_sel
  import store_pkg::*;
(
  input  logic [3:0] be,
  input  logic [1:0] cur_idx,
  input  logic       first,
  output logic [1:0] next_idx,
  output logic       has_next
);

  logic [3:0] mask;
  logic [3:0] cand;

  always_comb begin
    mask     = first ? 4'hF : (4'hE << cur_idx);
    cand     = be & mask;
    next_idx = '0;
    for (int i = BYTES_PER_WORD - 1; i >= 0; i--) begin
      if (cand[i]) next_idx = 2'(i);
    end
    has_next = |cand;
  end

endmodule

// File: rtl/word_store_serializer.sv
// Splits one 32-bit store into single-byte memory writes.
// Outputs decode from registers only; write port fields hold between stores.
module word_store_serializer
  import store_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_data_i,
  input  logic [3:0]        req_be_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wd_o,
  input  logic              mem_stall_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  state_t state_q, state_n;

  logic [ADDR_W-3:0] base_q, base_n;
  logic [31:0]       data_q, data_n;
  logic [3:0]        be_q, be_n;
  logic [1:0]        idx_q, idx_n;
  logic [ADDR_W-1:0] maddr_q, maddr_n;
  logic [7:0]        wd_q, wd_n;

  logic       sel_first;
  logic [3:0] sel_be;
  logic [1:0] sel_idx;
  logic       sel_has;

  // In IDLE the selector looks at the incoming request directly.
  assign sel_first = (state_q == S_IDLE);
  assign sel_be    = sel_first ? req_be_i : be_q;

  be_next_sel u_sel (
    .be       (sel_be),
    .cur_idx  (idx_q),
    .first    (sel_first),
    .next_idx (sel_idx),
    .has_next (sel_has)
  );

  always_comb begin
    state_n = state_q;
    base_n  = base_q;
    data_n  = data_q;
    be_n    = be_q;
    idx_n   = idx_q;
    maddr_n = maddr_q;
    wd_n    = wd_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          base_n = req_addr_i[ADDR_W-1:2];
          data_n = req_data_i;
          be_n   = req_be_i;
          if (req_addr_i[1:0] != 2'b00) begin
            state_n = S_ERR;
          end else if (!sel_has) begin
            state_n = S_DONE;
          end else begin
            idx_n   = sel_idx;
            maddr_n = {req_addr_i[ADDR_W-1:2], sel_idx};
            wd_n    = byte_sel(req_data_i, sel_idx, BIG_ENDIAN);
            state_n = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (!mem_stall_i) begin
          if (sel_has) begin
            idx_n   = sel_idx;
            maddr_n = {base_q, sel_idx};
            wd_n    = byte_sel(data_q, sel_idx, BIG_ENDIAN);
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      idx_q   <= '0;
      maddr_q <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_n;
      base_q  <= base_n;
      data_q  <= data_n;
      be_q    <= be_n;
      idx_q   <= idx_n;
      maddr_q <= maddr_n;
      wd_q    <= wd_n;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign mem_we_o    = (state_q == S_WRITE);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = (state_q == S_ERR);
  assign mem_addr_o  = maddr_q;
  assign mem_wd_o    = wd_q;

endmodule
